// File: rtl/touch_sample_filter.sv
// Touch sample filter: drops post-pen-down settling samples, averages N_AVG-sample
// bursts, rejects noisy bursts and holds each coordinate until the painter consumes it.
// Optional write-rate limit: define TOUCH_SAMPLE_FILTER_HOLDOFF_EN.
module touch_sample_filter #(
  parameter int          N_AVG          = 4,
  parameter int          N_AVG_LOG2     = $clog2(N_AVG),
  parameter int          SETTLE_SAMPLES = 2,
  parameter logic [11:0] MAX_SPREAD     = 12'd64,
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pen_down,
  input  logic        sample_valid,
  input  logic [11:0] x_raw,
  input  logic [11:0] y_raw,
  output logic        pos_ready,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        burst_rejected
);

  localparam int SUM_W    = 12 + N_AVG_LOG2;
  localparam int SETTLE_W = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);

`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_CHECK, S_REPORT, S_HOLDOFF} state_t;
  logic [15:0] holdoff_cnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_CHECK, S_REPORT} state_t;
  wire unused_holdoff = |HOLDOFF_CYCLES;
`endif

  state_t state, state_next;

  logic [SETTLE_W-1:0]   settle_cnt;
  logic [N_AVG_LOG2-1:0] sample_cnt;
  logic [SUM_W-1:0]      sum_x, sum_y;
  logic [11:0]           min_x, max_x, min_y, max_y;
  logic [11:0]           spread_x, spread_y;

  logic clear_acc, take_settle, take_sample, accept, reject, consume;

  assign spread_x = max_x - min_x;
  assign spread_y = max_y - min_y;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next  = state;
    clear_acc   = 1'b0;
    take_settle = 1'b0;
    take_sample = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    consume     = 1'b0;
    case (state)
      S_IDLE: begin
        clear_acc = 1'b1;
        if (pen_down) state_next = (SETTLE_SAMPLES == 0) ? S_ACCUM : S_SETTLE;
      end
      S_SETTLE: begin
        if (!pen_down) begin
          clear_acc  = 1'b1;
          state_next = S_IDLE;
        end else if (sample_valid) begin
          take_settle = 1'b1;
          if (settle_cnt == SETTLE_W'(SETTLE_SAMPLES - 1)) state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!pen_down) begin
          clear_acc  = 1'b1;
          state_next = S_IDLE;
        end else if (sample_valid) begin
          take_sample = 1'b1;
          if (sample_cnt == N_AVG_LOG2'(N_AVG - 1)) state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (spread_x > MAX_SPREAD || spread_y > MAX_SPREAD) begin
          reject     = 1'b1;
          clear_acc  = 1'b1;
          state_next = S_ACCUM;
        end else begin
          accept     = 1'b1;
          state_next = S_REPORT;
        end
      end
      S_REPORT: begin
        if (en) begin
          consume   = 1'b1;
          clear_acc = 1'b1;
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
          state_next = S_HOLDOFF;
`else
          state_next = pen_down ? S_ACCUM : S_IDLE;
`endif
        end
      end
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
      S_HOLDOFF: begin
        if (!pen_down) begin
          clear_acc  = 1'b1;
          state_next = S_IDLE;
        end else if (holdoff_cnt == HOLDOFF_CYCLES - 16'd1) begin
          state_next = S_ACCUM;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath; the first sample of a burst (sample_cnt == 0) seeds min and max.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt     <= '0;
      sample_cnt     <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      min_x          <= '0;
      max_x          <= '0;
      min_y          <= '0;
      max_y          <= '0;
      pos_ready      <= 1'b0;
      x_pos          <= '0;
      y_pos          <= '0;
      burst_rejected <= 1'b0;
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
      holdoff_cnt    <= '0;
`endif
    end else begin
      burst_rejected <= reject;
      if (clear_acc) begin
        settle_cnt <= '0;
        sample_cnt <= '0;
        sum_x      <= '0;
        sum_y      <= '0;
        min_x      <= '0;
        max_x      <= '0;
        min_y      <= '0;
        max_y      <= '0;
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
        holdoff_cnt <= '0;
`endif
      end else begin
        if (take_settle) settle_cnt <= settle_cnt + SETTLE_W'(1);
        if (take_sample) begin
          sample_cnt <= sample_cnt + N_AVG_LOG2'(1);
          sum_x      <= sum_x + SUM_W'(x_raw);
          sum_y      <= sum_y + SUM_W'(y_raw);
          if (sample_cnt == '0 || x_raw < min_x) min_x <= x_raw;
          if (sample_cnt == '0 || x_raw > max_x) max_x <= x_raw;
          if (sample_cnt == '0 || y_raw < min_y) min_y <= y_raw;
          if (sample_cnt == '0 || y_raw > max_y) max_y <= y_raw;
        end
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
        if (state == S_HOLDOFF) holdoff_cnt <= holdoff_cnt + 16'd1;
`endif
      end
      if (accept) begin
        pos_ready <= 1'b1;
        x_pos     <= sum_x[N_AVG_LOG2 +: 12];
        y_pos     <= sum_y[N_AVG_LOG2 +: 12];
      end else if (consume) begin
        pos_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_sample_filter.sv
// Directed bench for touch_sample_filter: settling, averaging, spread rejection,
// report hold/consume, pen-lift handling and (when enabled) the holdoff window.
module tb_touch_sample_filter;

`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
  localparam int HOLD_WAIT = 20;
`else
  localparam int HOLD_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        pen_down = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] x_raw = '0;
  logic [11:0] y_raw = '0;
  logic        pos_ready;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        burst_rejected;

  int total = 0;
  int bad   = 0;

  touch_sample_filter #(
    .N_AVG          (4),
    .SETTLE_SAMPLES (2),
    .MAX_SPREAD     (12'd64),
    .HOLDOFF_CYCLES (16'(HOLD_WAIT == 0 ? 50000 : HOLD_WAIT))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .pen_down       (pen_down),
    .sample_valid   (sample_valid),
    .x_raw          (x_raw),
    .y_raw          (y_raw),
    .pos_ready      (pos_ready),
    .x_pos          (x_pos),
    .y_pos          (y_pos),
    .burst_rejected (burst_rejected)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] y);
    sample_valid = 1'b1;
    x_raw        = x;
    y_raw        = y;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic consume();
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (HOLD_WAIT) tick();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    pen_down = 1'b1;
    for (int i = 0; i < 4; i++) send(12'($urandom), 12'($urandom));
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", pos_ready); end
    total++; if (x_pos !== 12'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", x_pos); end
    total++; if (y_pos !== 12'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", y_pos); end
    total++; if (burst_rejected !== 1'b0) begin bad++; $display("FAIL reset_rej got=%b want=0", burst_rejected); end
    pen_down = 1'b0;
    reset    = 1'b0;
    repeat (3) tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL idle_rdy got=%b want=0", pos_ready); end
  endtask

  task automatic test_basic();
    pen_down = 1'b1;
    tick();
    send(12'd4095, 12'd4095);
    send(12'd4095, 12'd4095);
    send(12'd1000, 12'd2000);
    send(12'd1002, 12'd2000);
    send(12'd1004, 12'd2000);
    send(12'd1006, 12'd2000);
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL basic_check_rdy got=%b want=0", pos_ready); end
    tick();
    total++; if (pos_ready !== 1'b1) begin bad++; $display("FAIL basic_rdy got=%b want=1", pos_ready); end
    total++; if (x_pos !== 12'd1003) begin bad++; $display("FAIL basic_x got=%0d want=1003", x_pos); end
    total++; if (y_pos !== 12'd2000) begin bad++; $display("FAIL basic_y got=%0d want=2000", y_pos); end
    en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b want=0", pos_ready); end
    total++; if (x_pos !== 12'd1003) begin bad++; $display("FAIL basic_x_kept got=%0d want=1003", x_pos); end
    repeat (HOLD_WAIT) tick();
  endtask

  task automatic test_spread();
    send(12'd1000, 12'd500);
    send(12'd1000, 12'd500);
    send(12'd1000, 12'd500);
    send(12'd1100, 12'd500);
    tick();
    total++; if (burst_rejected !== 1'b1) begin bad++; $display("FAIL rej_pulse got=%b want=1", burst_rejected); end
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL rej_rdy got=%b want=0", pos_ready); end
    tick();
    total++; if (burst_rejected !== 1'b0) begin bad++; $display("FAIL rej_pulse_end got=%b want=0", burst_rejected); end
    for (int i = 0; i < 4; i++) send(12'd500, 12'd500);
    tick();
    total++; if (pos_ready !== 1'b1) begin bad++; $display("FAIL after_rej_rdy got=%b want=1", pos_ready); end
    total++; if (x_pos !== 12'd500 || y_pos !== 12'd500) begin bad++; $display("FAIL after_rej_xy got=%0d/%0d want=500/500", x_pos, y_pos); end
    consume();
    // Spread of exactly 64 on both axes is accepted.
    send(12'd100, 12'd0);
    send(12'd164, 12'd64);
    send(12'd100, 12'd32);
    send(12'd164, 12'd32);
    tick();
    total++; if (burst_rejected !== 1'b0) begin bad++; $display("FAIL edge64_rej got=%b want=0", burst_rejected); end
    total++; if (pos_ready !== 1'b1) begin bad++; $display("FAIL edge64_rdy got=%b want=1", pos_ready); end
    total++; if (x_pos !== 12'd132 || y_pos !== 12'd32) begin bad++; $display("FAIL edge64_xy got=%0d/%0d want=132/32", x_pos, y_pos); end
    consume();
    // Y spread of 65 alone is enough to reject.
    send(12'd10, 12'd0);
    send(12'd10, 12'd65);
    send(12'd10, 12'd0);
    send(12'd10, 12'd0);
    tick();
    total++; if (burst_rejected !== 1'b1) begin bad++; $display("FAIL y65_rej got=%b want=1", burst_rejected); end
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL y65_rdy got=%b want=0", pos_ready); end
    tick();
  endtask

  task automatic test_pen_drop();
    send(12'd700, 12'd700);
    send(12'd700, 12'd700);
    pen_down = 1'b0;
    send(12'd700, 12'd700);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL drop_rdy got=%b want=0", pos_ready); end
    pen_down = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(12'd300, 12'd300);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL drop_resettle got=%b want=0", pos_ready); end
    send(12'd300, 12'd300);
    send(12'd300, 12'd300);
    tick();
    total++; if (pos_ready !== 1'b1) begin bad++; $display("FAIL drop_rdy2 got=%b want=1", pos_ready); end
    total++; if (x_pos !== 12'd300 || y_pos !== 12'd300) begin bad++; $display("FAIL drop_xy got=%0d/%0d want=300/300", x_pos, y_pos); end
    consume();
  endtask

  task automatic test_report_hold();
    for (int i = 0; i < 4; i++) send(12'd800, 12'd900);
    tick();
    for (int i = 0; i < 10; i++) begin
      sample_valid = i[0];
      x_raw        = 12'd4000;
      y_raw        = 12'd4000;
      tick();
      total++;
      if (pos_ready !== 1'b1 || x_pos !== 12'd800 || y_pos !== 12'd900) begin
        bad++;
        $display("FAIL hold_%0d got=%b %0d/%0d want=1 800/900", i, pos_ready, x_pos, y_pos);
      end
    end
    en           = 1'b1;
    sample_valid = 1'b1;
    tick();
    en           = 1'b0;
    sample_valid = 1'b0;
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL hold_consume got=%b want=0", pos_ready); end
    repeat (HOLD_WAIT) tick();
    for (int i = 0; i < 3; i++) send(12'd1200, 12'd1300);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL hold_dropped_sample got=%b want=0", pos_ready); end
    send(12'd1200, 12'd1300);
    tick();
    total++; if (pos_ready !== 1'b1) begin bad++; $display("FAIL hold_next_rdy got=%b want=1", pos_ready); end
    total++; if (x_pos !== 12'd1200 || y_pos !== 12'd1300) begin bad++; $display("FAIL hold_next_xy got=%0d/%0d want=1200/1300", x_pos, y_pos); end
  endtask

  task automatic test_pen_lift_report();
    pen_down = 1'b0;
    tick();
    tick();
    total++; if (pos_ready !== 1'b1 || x_pos !== 12'd1200) begin bad++; $display("FAIL lift_held got=%b %0d want=1 1200", pos_ready, x_pos); end
    consume();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL lift_consume got=%b want=0", pos_ready); end
    pen_down = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(12'd50, 12'd60);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL lift_resettle got=%b want=0", pos_ready); end
    send(12'd50, 12'd60);
    send(12'd50, 12'd60);
    tick();
    total++; if (pos_ready !== 1'b1 || x_pos !== 12'd50 || y_pos !== 12'd60) begin bad++; $display("FAIL lift_next got=%b %0d/%0d want=1 50/60", pos_ready, x_pos, y_pos); end
  endtask

`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
  task automatic test_holdoff();
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < HOLD_WAIT; i++) send(12'd4095, 12'd4095);
    for (int i = 0; i < 3; i++) send(12'd100, 12'd110);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL holdoff_ignored got=%b want=0", pos_ready); end
    send(12'd100, 12'd110);
    tick();
    total++; if (pos_ready !== 1'b1 || x_pos !== 12'd100 || y_pos !== 12'd110) begin bad++; $display("FAIL holdoff_next got=%b %0d/%0d want=1 100/110", pos_ready, x_pos, y_pos); end
    en = 1'b1;
    tick();
    en       = 1'b0;
    pen_down = 1'b0;
    tick();
    pen_down = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(12'd70, 12'd70);
    tick();
    total++; if (pos_ready !== 1'b0) begin bad++; $display("FAIL holdoff_lift got=%b want=0", pos_ready); end
    send(12'd70, 12'd70);
    send(12'd70, 12'd70);
    tick();
    total++; if (pos_ready !== 1'b1 || x_pos !== 12'd70) begin bad++; $display("FAIL holdoff_lift_next got=%b %0d want=1 70", pos_ready, x_pos); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_spread();
    test_pen_drop();
    test_report_hold();
    test_pen_lift_report();
`ifdef TOUCH_SAMPLE_FILTER_HOLDOFF_EN
    test_holdoff();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
